// File: rtl/crc24_gen.sv
// Bit-serial BLE CRC-24 generator: passes PDU bits through while running the LFSR,
// then appends the 24 CRC bits MSB first, one every CRC_BIT_INTERVAL clocks.
//
// state | meaning
// IDLE  | not armed; input strobes ignored, no output
// DATA  | armed; each valid PDU bit is passed through and folded into the LFSR
// CRC   | emitting lfsr[23] at each interval terminal count, 24 bits total
module crc24_gen #(
  parameter int CRC_BIT_INTERVAL = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] crc_state_init_bit,
  input  logic        crc_state_init_bit_load,
  input  logic        data_in,
  input  logic        data_in_valid,
  input  logic        data_in_valid_last,
  output logic        data_out,
  output logic        data_out_valid,
  output logic        data_out_valid_last,
  output logic        busy
);

  localparam int IW = (CRC_BIT_INTERVAL > 1) ? $clog2(CRC_BIT_INTERVAL) : 1;
  localparam logic [IW-1:0] IVL_RELOAD = IW'(CRC_BIT_INTERVAL - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [23:0]   lfsr, lfsr_nxt, lfsr_fb;
  logic [IW-1:0] ivl_cnt, ivl_cnt_nxt;
  logic [4:0]    bit_cnt, bit_cnt_nxt;
  logic          fb;
  logic          dout_nxt, dout_vld_nxt, dout_last_nxt, busy_nxt;

  // Galois form of x^24+x^10+x^9+x^6+x^4+x^3+x+1, taps at 1,3,4,6,9,10
  assign fb      = data_in ^ lfsr[23];
  assign lfsr_fb = {lfsr[22:10], lfsr[9] ^ fb, lfsr[8] ^ fb, lfsr[7:6], lfsr[5] ^ fb,
                    lfsr[4], lfsr[3] ^ fb, lfsr[2] ^ fb, lfsr[1], lfsr[0] ^ fb, fb};

  always_comb begin
    state_nxt     = state;
    lfsr_nxt      = lfsr;
    ivl_cnt_nxt   = ivl_cnt;
    bit_cnt_nxt   = bit_cnt;
    dout_nxt      = data_out;
    dout_vld_nxt  = 1'b0;
    dout_last_nxt = 1'b0;
    busy_nxt      = busy;

    if (crc_state_init_bit_load) begin
      // load wins over a same-cycle data strobe and aborts any packet in flight
      state_nxt   = ST_DATA;
      lfsr_nxt    = crc_state_init_bit;
      ivl_cnt_nxt = '0;
      bit_cnt_nxt = '0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: busy_nxt = 1'b0;
        ST_DATA: begin
          if (data_in_valid) begin
            dout_nxt     = data_in;
            dout_vld_nxt = 1'b1;
            lfsr_nxt     = lfsr_fb;
            busy_nxt     = 1'b1;
            if (data_in_valid_last) begin
              state_nxt   = ST_CRC;
              ivl_cnt_nxt = IVL_RELOAD;
              bit_cnt_nxt = '0;
            end
          end
        end
        ST_CRC: begin
          if (ivl_cnt == '0) begin
            dout_nxt     = lfsr[23];
            dout_vld_nxt = 1'b1;
            lfsr_nxt     = {lfsr[22:0], 1'b0};
            ivl_cnt_nxt  = IVL_RELOAD;
            if (bit_cnt == 5'd23) begin
              dout_last_nxt = 1'b1;
              bit_cnt_nxt   = '0;
              state_nxt     = ST_IDLE;
            end else begin
              bit_cnt_nxt = bit_cnt + 5'd1;
            end
          end else begin
            ivl_cnt_nxt = ivl_cnt - 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      lfsr                <= '0;
      ivl_cnt             <= '0;
      bit_cnt             <= '0;
      data_out            <= 1'b0;
      data_out_valid      <= 1'b0;
      data_out_valid_last <= 1'b0;
      busy                <= 1'b0;
    end else begin
      state               <= state_nxt;
      lfsr                <= lfsr_nxt;
      ivl_cnt             <= ivl_cnt_nxt;
      bit_cnt             <= bit_cnt_nxt;
      data_out            <= dout_nxt;
      data_out_valid      <= dout_vld_nxt;
      data_out_valid_last <= dout_last_nxt;
      busy                <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_crc24_gen.sv
// Scoreboard bench for crc24_gen: stimulus pushes expected bits with their output
// cycle, an independent monitor pops and compares on every data_out_valid.
module tb_crc24_gen;

  localparam int INTERVAL = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] crc_state_init_bit = '0;
  logic        crc_state_init_bit_load = 1'b0;
  logic        data_in = 1'b0;
  logic        data_in_valid = 1'b0;
  logic        data_in_valid_last = 1'b0;
  logic        data_out, data_out_valid, data_out_valid_last, busy;

  crc24_gen #(.CRC_BIT_INTERVAL(INTERVAL)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .crc_state_init_bit      (crc_state_init_bit),
    .crc_state_init_bit_load (crc_state_init_bit_load),
    .data_in                 (data_in),
    .data_in_valid           (data_in_valid),
    .data_in_valid_last      (data_in_valid_last),
    .data_out                (data_out),
    .data_out_valid          (data_out_valid),
    .data_out_valid_last     (data_out_valid_last),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        b;
    logic        last;
    int unsigned at;
  } exp_t;

  exp_t        exp_q[$];
  logic        pdu_q[$];
  logic [23:0] m_crc;
  bit          m_armed = 1'b0;
  int unsigned last_t = 0;
  int          checks = 0;
  int          errors = 0;
  int          n_vld = 0;
  int          n_last = 0;
  bit          busy_chk = 1'b0;

  // CRC register advanced one message bit: shift left, xor in the polynomial when the
  // bit leaving the top differs from the data bit
  function automatic logic [23:0] crc_next(input logic [23:0] s, input logic d);
    return {s[22:0], 1'b0} ^ (((s >> 23) & 24'h1) != {23'h0, d} ? 24'h00065B : 24'h0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busy_chk) begin
        check("busy_after_last", {31'h0, busy}, 32'h0);
        busy_chk = 1'b0;
      end
      if (data_out_valid) begin
        n_vld++;
        if (data_out_valid_last) n_last++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=valid bit %0b required=no output at cycle %0d",
                   data_out, cyc);
        end else begin
          e = exp_q.pop_front();
          check("out_bit", {31'h0, data_out}, {31'h0, e.b});
          check("out_last", {31'h0, data_out_valid_last}, {31'h0, e.last});
          check("out_cycle", cyc, e.at);
          check("busy_during_out", {31'h0, busy}, 32'h1);
          if (e.last) busy_chk = 1'b1;
        end
      end else if (data_out_valid_last) begin
        check("last_without_valid", {31'h0, data_out_valid_last}, 32'h0);
      end
    end
  end

  task automatic do_load(input logic [23:0] init, input logic with_valid);
    exp_t        keep[$];
    int unsigned l;
    @(posedge clk); #1;
    crc_state_init_bit      = init;
    crc_state_init_bit_load = 1'b1;
    data_in_valid           = with_valid;
    data_in                 = 1'b1;
    l = cyc;
    foreach (exp_q[i]) if (exp_q[i].at <= l) keep.push_back(exp_q[i]);
    exp_q   = keep;
    m_crc   = init;
    m_armed = 1'b1;
    @(posedge clk); #1;
    crc_state_init_bit_load = 1'b0;
    data_in_valid           = 1'b0;
  endtask

  task automatic send_bit(input logic d, input logic last, input bit ovr, input logic [23:0] ovr_crc);
    exp_t        e;
    int unsigned t;
    logic [23:0] c;
    @(posedge clk); #1;
    data_in            = d;
    data_in_valid      = 1'b1;
    data_in_valid_last = last;
    t = cyc;
    if (m_armed) begin
      e.b = d; e.last = 1'b0; e.at = t + 1;
      exp_q.push_back(e);
      m_crc = crc_next(m_crc, d);
      if (last) begin
        last_t  = t;
        m_armed = 1'b0;
        c = ovr ? ovr_crc : m_crc;
        for (int k = 0; k < 24; k++) begin
          e.b    = c[23-k];
          e.last = (k == 23);
          e.at   = t + 1 + 32'(k + 1) * 32'(INTERVAL);
          exp_q.push_back(e);
        end
      end
    end
    @(posedge clk); #1;
    data_in_valid      = 1'b0;
    data_in_valid_last = 1'b0;
    data_in            = 1'($urandom);
  endtask

  task automatic send_seq(input bit ovr, input logic [23:0] ovr_crc);
    for (int i = 0; i < pdu_q.size(); i++) begin
      send_bit(pdu_q[i], i == pdu_q.size() - 1, ovr, ovr_crc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic rand_pdu(input int n);
    pdu_q.delete();
    for (int i = 0; i < n; i++) pdu_q.push_back(1'($urandom));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s actual=%0d outputs pending required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [23:0] saved;
    logic        keep_pdu[$];

    repeat (3) @(posedge clk); #1;
    check("rst_data_out", {31'h0, data_out}, 32'h0);
    check("rst_valid", {31'h0, data_out_valid}, 32'h0);
    check("rst_last", {31'h0, data_out_valid_last}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;

    // strobes before any load must be ignored
    send_bit(1'b1, 1'b0, 1'b0, 24'h0);
    send_bit(1'b0, 1'b1, 1'b0, 24'h0);
    repeat (5) @(posedge clk);

    // single bit 1 from zero init: CRC 0x00065B, last 385 clocks after the strobe
    do_load(24'h000000, 1'b0);
    n_vld = 0; n_last = 0;
    pdu_q.delete(); pdu_q.push_back(1'b1);
    send_seq(1'b1, 24'h00065B);
    wait_drain("single");
    check("single_pulses", n_vld, 32'd25);
    check("single_lasts", n_last, 32'd1);

    // 40 zeros from zero init
    do_load(24'h000000, 1'b0);
    n_vld = 0; n_last = 0;
    pdu_q.delete();
    repeat (40) pdu_q.push_back(1'b0);
    send_seq(1'b1, 24'h000000);
    wait_drain("zeros");
    check("zeros_pulses", n_vld, 32'd64);
    check("zeros_lasts", n_last, 32'd1);

    // random advertising-channel packets
    for (int p = 0; p < 4; p++) begin
      do_load(24'h555555, 1'b0);
      rand_pdu($urandom_range(1, 60));
      send_seq(1'b0, 24'h0);
      wait_drain("adv");
    end

    // PDU followed by its own CRC must leave a zero remainder
    do_load(24'h555555, 1'b0);
    rand_pdu(30);
    send_seq(1'b0, 24'h0);
    saved = m_crc;
    wait_drain("resid_a");
    do_load(24'h555555, 1'b0);
    for (int k = 0; k < 24; k++) pdu_q.push_back(saved[23-k]);
    send_seq(1'b1, 24'h000000);
    wait_drain("resid_b");

    // ignored inputs: last without valid, load with same-cycle valid, valid during CRC
    do_load(24'($urandom), 1'b0);
    send_bit(1'b1, 1'b0, 1'b0, 24'h0);
    @(posedge clk); #1;
    data_in_valid_last = 1'b1;
    @(posedge clk); #1;
    data_in_valid_last = 1'b0;
    send_bit(1'b0, 1'b0, 1'b0, 24'h0);
    do_load(24'($urandom), 1'b1);
    rand_pdu(12);
    send_seq(1'b0, 24'h0);
    repeat (20) @(posedge clk);
    send_bit(1'b1, 1'b0, 1'b0, 24'h0);
    repeat (30) @(posedge clk);
    send_bit(1'b0, 1'b1, 1'b0, 24'h0);
    wait_drain("ignored");

    // load between CRC bits 9 and 10 aborts; rerun the same packet cleanly
    do_load(24'h555555, 1'b0);
    rand_pdu(9);
    keep_pdu = pdu_q;
    n_vld = 0; n_last = 0;
    send_seq(1'b0, 24'h0);
    while (cyc < last_t + 1 + 10 * INTERVAL + INTERVAL / 2) @(posedge clk);
    do_load(24'h555555, 1'b0);
    repeat (30 * INTERVAL) @(posedge clk);
    check("abort_pulses", n_vld, 32'd19);
    check("abort_lasts", n_last, 32'd0);
    do_load(24'h555555, 1'b0);
    pdu_q = keep_pdu;
    send_seq(1'b0, 24'h0);
    wait_drain("after_abort");

    // reset mid-DATA with an output in flight
    do_load(24'h555555, 1'b0);
    rand_pdu(5);
    send_seq(1'b0, 24'h0);
    @(posedge clk); #1;
    data_in = 1'b1; data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    m_armed = 1'b0;
    #1;
    check("rst_inflight_valid", {31'h0, data_out_valid}, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_outs", {28'h0, data_out, data_out_valid, data_out_valid_last, busy}, 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_bit(1'b1, 1'b0, 1'b0, 24'h0);
    send_bit(1'b1, 1'b1, 1'b0, 24'h0);
    repeat (5) @(posedge clk);
    do_load(24'h555555, 1'b0);
    rand_pdu(20);
    send_seq(1'b0, 24'h0);
    wait_drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
